// File: rtl/risac_avmm_port.sv
// risac_avmm_port: bridge from a risac native load/store/fetch port to an Avalon-MM master.
// Steers byte lanes for reads and writes, and sign- or zero-extends sub-word reads.
// Catches misaligned and oversize accesses before any bus cycle is issued.
// An optional watchdog aborts a slave that holds waitrequest high for too long.
module risac_avmm_port #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [1:0]          cpu_size,
  input  logic                cpu_unsigned,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_ack,
  output logic                cpu_err,
  output logic                busy,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state_q, state_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  rd_q, rd_d;
  logic               cmd_rd_q, cmd_rd_d, cmd_wr_q, cmd_wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BYTES-1:0]   be_q, be_d;
  logic [DATA_W-1:0]  wd_q, wd_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [OFF_W-1:0]   off_q, off_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [OFF_W-1:0]   off;
  logic               illegal, misal;
  logic [BYTES-1:0]   req_be;
  logic [DATA_W-1:0]  req_wd;
  logic [DATA_W-1:0]  sh, ext;
  logic               top, sgn;
  int                 nbits;

  assign off = cpu_addr[OFF_W-1:0];

  // Decode the incoming request: legality, alignment, lane enables and lane-steered write data.
  always_comb begin
    illegal = (1 << cpu_size) > BYTES;
    misal   = (off & OFF_W'((1 << cpu_size) - 1)) != '0;
    for (int b = 0; b < BYTES; b++)
      req_be[b] = (b >= int'(off)) && (b < int'(off) + (1 << cpu_size));
    req_wd = cpu_wdata << {off, 3'b000};
  end

  // Right-align the read lanes, then extend from the top bit of the accessed field.
  always_comb begin
    sh    = avm_readdata >> {off_q, 3'b000};
    nbits = 8 << size_q;
    case (size_q)
      2'd0:    top = sh[7];
      2'd1:    top = sh[15];
      2'd2:    top = sh[31];
      default: top = sh[DATA_W-1];
    endcase
    sgn = top & ~uns_q;
    for (int i = 0; i < DATA_W; i++)
      ext[i] = (i < nbits) ? sh[i] : sgn;
  end

  // Next-state logic: accept in IDLE, wait out the slave in ACCESS, pulse the response in RESP.
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    rd_d     = rd_q;
    cmd_rd_d = cmd_rd_q;
    cmd_wr_d = cmd_wr_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wd_d     = wd_q;
    size_d   = size_q;
    uns_d    = uns_q;
    off_d    = off_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: if (cpu_req) begin
        if (illegal || misal) begin
          // Bad requests are answered locally; the bus never sees them.
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          addr_d   = {cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          be_d     = req_be;
          wd_d     = req_wd;
          size_d   = cpu_size;
          uns_d    = cpu_unsigned;
          off_d    = off;
          cmd_rd_d = ~cpu_we;
          cmd_wr_d = cpu_we;
          cnt_d    = '0;
          err_d    = 1'b0;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (!avm_waitrequest) begin
          cmd_rd_d = 1'b0;
          cmd_wr_d = 1'b0;
          if (cmd_rd_q) rd_d = ext;
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (TIMEOUT != 0) begin
          if (cnt_q == CNT_MAX) begin
            cmd_rd_d = 1'b0;
            cmd_wr_d = 1'b0;
            err_d    = 1'b1;
            state_d  = RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and bus-side registers; reset drops the Avalon command immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      err_q    <= 1'b0;
      rd_q     <= '0;
      cmd_rd_q <= 1'b0;
      cmd_wr_q <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wd_q     <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      off_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
      cmd_rd_q <= cmd_rd_d;
      cmd_wr_q <= cmd_wr_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wd_q     <= wd_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      off_q    <= off_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cpu_rdata      = rd_q;
  assign cpu_ack        = (state_q == RESP);
  assign cpu_err        = cpu_ack & err_q;
  assign busy           = (state_q != IDLE);
  assign avm_address    = addr_q;
  assign avm_read       = cmd_rd_q;
  assign avm_write      = cmd_wr_q;
  assign avm_writedata  = wd_q;
  assign avm_byteenable = be_q;
endmodule
